zigbee_msk_mod_top: RTL
=======================

ZIGBEE_MSK_MOD_TOP -- requirements
Module: zigbee_msk_mod_top

Interface
REQ-001 Parameter IQ_SIZE, default 5: width in bits of the signed ibb/qbb output samples.
REQ-002 Parameter W_SIZE, default 6: width in bits of the phase accumulator; full turn = 2^W_SIZE.
REQ-003 Parameter OSR, default 4: samples per chip; power of two, at most 2^(W_SIZE-2).
REQ-004 clk  input  1  sole clock; all state on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 chip  input  1  chip value; 1 = phase advances +90°, 0 = phase retards -90°.
REQ-007 chipValid  input  1  chip is presented.
REQ-008 chipReady  output  1  block accepts chip this cycle; handshake = chipValid && chipReady.
REQ-009 ibb  output  IQ_SIZE  signed in-phase sample.
REQ-010 qbb  output  IQ_SIZE  signed quadrature sample.
REQ-011 oValid  output  1  ibb/qbb hold a valid sample.

Function
REQ-012 STEP shall be 2^(W_SIZE-2)/OSR; one chip moves the phase by exactly ±2^(W_SIZE-2) (quarter turn).
REQ-013 FSM states IDLE and RUN; sample counter cnt runs 0..OSR-1.
REQ-014 chipReady shall be combinational: 1 in IDLE, 1 in RUN when cnt==OSR-1, else 0.
REQ-015 IDLE + handshake: latch chip as dir, cnt<=0, go RUN; phase unchanged.
REQ-016 RUN, each cycle: phase <= phase ± STEP (modulo 2^W_SIZE, sign from dir); cnt <= cnt+1.
REQ-017 RUN, cnt==OSR-1 with handshake: latch new dir, cnt<=0, stay RUN (gapless, no idle cycle).
REQ-018 RUN, cnt==OSR-1 without handshake: go IDLE; phase keeps its value (phase continuity across gaps).
REQ-019 Output registers: oValid <= (state==RUN); ibb/qbb <= sincos(phase) using the pre-update phase value.
REQ-020 Latency: handshake at edge E -> first sample of that chip (phase at chip start) valid after edge E+1; OSR consecutive samples follow.
REQ-021 sincos: ibb = round(A*cos(2π·phase/2^W_SIZE)), qbb = round(A*sin(...)), A = 2^(IQ_SIZE-1)-1, round half away from zero; never -2^(IQ_SIZE-1).
REQ-022 In IDLE, oValid = 0 and ibb/qbb hold their last value.

Reset
REQ-023 reset_n low: state=IDLE, cnt=0, dir=0, phase=0, ibb=0, qbb=0, oValid=0, chipReady=1; applies immediately, including mid-chip.
REQ-024 After reset release, the first chip starts at phase 0.

Configuration
REQ-025 Macro ZIGBEE_MSK_MOD_UNDERRUN_EN defined: add output port underrun (1 bit), a sticky flag set when REQ-018 fires, cleared only by reset.
REQ-026 Macro undefined: no underrun port and no flag logic; all other behaviour identical.

Structure
REQ-027 Package zigbee_msk_pkg shall hold the FSM state typedef (IDLE, RUN) and the default IQ_SIZE/W_SIZE/OSR constants.
REQ-028 Sub-module zigbee_msk_sincos_lut: combinational, phase in (W_SIZE), ibb/qbb out, quarter-wave table with symmetry folding.

Verification (IQ_SIZE=5, W_SIZE=6, OSR=4, STEP=4)
REQ-029 Reset, one chip=1 -> phases 0,4,8,12 -> ibb 15,14,11,6; qbb 0,6,11,14; oValid high 4 cycles, first after E+1.
REQ-030 Reset, one chip=0 -> phases 0,60,56,52 -> ibb 15,14,11,6; qbb 0,-6,-11,-14.
REQ-031 Chips 1,1 back-to-back -> 8 contiguous oValid cycles; 5th sample ibb=0, qbb=15; chipReady pulses only at cnt==3.
REQ-032 Chip 1, 3-cycle gap, chip 1 -> oValid low in gap; second chip starts at phase 16 (ibb=0, qbb=15); underrun=1 when macro defined.
REQ-033 reset_n asserted at cnt==2 -> all outputs at reset values asynchronously; next chip starts at phase 0.
REQ-034 Four chips 0 -> phase returns to 0; next sample ibb=15, qbb=0 (wrap-around).

Source files
------------

// File: rtl/zigbee_msk_pkg.sv
// Shared types and default sizing for the ZigBee MSK (half-sine O-QPSK) modulator.
package zigbee_msk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } msk_state_t;

    localparam int DEF_IQ_SIZE = 5;
    localparam int DEF_W_SIZE  = 6;
    localparam int DEF_OSR     = 4;

endpackage

// File: rtl/zigbee_msk_mod_if.sv
// Chip input handshake and I/Q sample output bundle of the MSK modulator.
interface zigbee_msk_mod_if
    import zigbee_msk_pkg::*;
#(
    parameter int IQ_SIZE = DEF_IQ_SIZE
);
    logic                      chip;
    logic                      chipValid;
    logic                      chipReady;
    logic signed [IQ_SIZE-1:0] ibb;
    logic signed [IQ_SIZE-1:0] qbb;
    logic                      oValid;

    modport master (
        output chip,
        output chipValid,
        input  chipReady,
        input  ibb,
        input  qbb,
        input  oValid
    );

    modport slave (
        input  chip,
        input  chipValid,
        output chipReady,
        output ibb,
        output qbb,
        output oValid
    );
endinterface

// File: rtl/zigbee_msk_sincos_lut.sv
// Combinational cos/sin of a W_SIZE-bit phase from one quarter-wave sine table.
// The table is built at elaboration; rounding is half away from zero.
module zigbee_msk_sincos_lut
    import zigbee_msk_pkg::*;
#(
    parameter int IQ_SIZE = DEF_IQ_SIZE,
    parameter int W_SIZE  = DEF_W_SIZE
) (
    input  logic [W_SIZE-1:0]         phase,
    output logic signed [IQ_SIZE-1:0] ibb,
    output logic signed [IQ_SIZE-1:0] qbb
);
    localparam int QTR = 1 << (W_SIZE - 2);
    localparam int AMP = (1 << (IQ_SIZE - 1)) - 1;

    // Taylor series is accurate far beyond one LSB over [0, pi/2].
    function automatic int sin_entry(input int k);
        real x;
        real term;
        real sum;
        x    = 6.283185307179586 * real'(k) / real'(1 << W_SIZE);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return int'(real'(AMP) * sum);
    endfunction

    logic [IQ_SIZE-1:0]        sin_tab [0:QTR];
    logic [W_SIZE-1:0]         ph      [2];
    logic signed [IQ_SIZE-1:0] res     [2];

    // Channel 0 is cosine: sine of the phase advanced by a quarter turn.
    assign ph[0] = phase + W_SIZE'(QTR);
    assign ph[1] = phase;
    assign ibb   = res[0];
    assign qbb   = res[1];

    genvar gi;
    generate
        for (gi = 0; gi <= QTR; gi++) begin : g_tab
            assign sin_tab[gi] = IQ_SIZE'(sin_entry(gi));
        end

        for (gi = 0; gi < 2; gi++) begin : g_fold
            logic [W_SIZE-2:0]  idx;
            logic [IQ_SIZE-1:0] mag;
            // Odd quadrants mirror the table, the lower half-turn is negated.
            assign idx = ph[gi][W_SIZE-2]
                       ? (W_SIZE-1)'(QTR) - {1'b0, ph[gi][W_SIZE-3:0]}
                       : {1'b0, ph[gi][W_SIZE-3:0]};
            assign mag     = sin_tab[idx];
            assign res[gi] = ph[gi][W_SIZE-1] ? -$signed(mag) : $signed(mag);
        end
    endgenerate

endmodule

// File: rtl/zigbee_msk_mod_top.sv
// MSK modulator: each chip rotates the phase a quarter turn over OSR samples.
// Optional sticky underrun flag under macro ZIGBEE_MSK_MOD_UNDERRUN_EN.
module zigbee_msk_mod_top
    import zigbee_msk_pkg::*;
#(
    parameter int IQ_SIZE = DEF_IQ_SIZE,
    parameter int W_SIZE  = DEF_W_SIZE,
    parameter int OSR     = DEF_OSR
) (
    input  logic              clk,
    input  logic              reset_n,
    zigbee_msk_mod_if.slave   bus
`ifdef ZIGBEE_MSK_MOD_UNDERRUN_EN
    ,
    output logic              underrun
`endif
);
    localparam int                CW     = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [CW-1:0]     LAST   = CW'(OSR - 1);
    localparam logic [W_SIZE-1:0] STEP_W = W_SIZE'((1 << (W_SIZE - 2)) / OSR);

    msk_state_t                state_reg, state_next;
    logic [CW-1:0]             cnt_reg, cnt_next;
    logic                      dir_reg, dir_next;
    logic [W_SIZE-1:0]         phase_reg, phase_next;
    logic signed [IQ_SIZE-1:0] ibb_reg, qbb_reg;
    logic signed [IQ_SIZE-1:0] lut_i, lut_q;
    logic                      valid_reg;
    logic                      last;
    logic                      chip_ready;
    logic                      hs;

    zigbee_msk_sincos_lut #(
        .IQ_SIZE (IQ_SIZE),
        .W_SIZE  (W_SIZE)
    ) u_lut (
        .phase (phase_reg),
        .ibb   (lut_i),
        .qbb   (lut_q)
    );

    assign last       = (cnt_reg == LAST);
    assign chip_ready = (state_reg == IDLE) || last;
    assign hs         = bus.chipValid && chip_ready;

    assign bus.chipReady = chip_ready;
    assign bus.ibb       = ibb_reg;
    assign bus.qbb       = qbb_reg;
    assign bus.oValid    = valid_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        phase_next = phase_reg;
        case (state_reg)
            IDLE: begin
                if (hs) begin
                    dir_next   = bus.chip;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                phase_next = dir_reg ? phase_reg + STEP_W : phase_reg - STEP_W;
                if (last) begin
                    cnt_next = '0;
                    // Accepting here keeps the chip stream gapless.
                    if (hs) begin
                        dir_next = bus.chip;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            dir_reg   <= 1'b0;
            phase_reg <= '0;
            ibb_reg   <= '0;
            qbb_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            phase_reg <= phase_next;
            valid_reg <= (state_reg == RUN);
            // Samples use the phase before this cycle's update; hold while idle.
            if (state_reg == RUN) begin
                ibb_reg <= lut_i;
                qbb_reg <= lut_q;
            end
        end
    end

`ifdef ZIGBEE_MSK_MOD_UNDERRUN_EN
    logic underrun_reg;
    logic gap;

    assign gap      = (state_reg == RUN) && last && !hs;
    assign underrun = underrun_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_reg <= 1'b0;
        end else if (gap) begin
            underrun_reg <= 1'b1;
        end
    end
`endif

endmodule
